// File: rtl/mcu_el2_pkg.sv
// Shared types and constants for the EL2 LSU store queue.
package mcu_el2_pkg;

    // Default queue geometry.
    localparam int STBUF_DEPTH  = 4;
    localparam int STBUF_ADDR_W = 32;

    // Pointer width: index bits plus one wrap bit for full/empty disambiguation.
    localparam int STBUF_PTR_W  = $clog2(STBUF_DEPTH) + 1;

    // One committed store. The address is kept word-aligned (bits [1:0] zero)
    // and sized for the widest supported address.
    typedef struct packed {
        logic                    valid;
        logic [STBUF_ADDR_W-1:0] addr;
        logic [31:0]             data;
        logic [3:0]              byteen;
    } mcu_el2_stbuf_entry_t;

endpackage

// File: rtl/mcu_el2_lsu_stbuf_fwd.sv
// Combinational store-to-load forwarding: youngest-first byte merge over the
// live entries of the store queue.
module mcu_el2_lsu_stbuf_fwd
    import mcu_el2_pkg::*;
#(
    parameter int DEPTH  = STBUF_DEPTH,
    parameter int ADDR_W = STBUF_ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  mcu_el2_stbuf_entry_t entries [DEPTH],
    input  logic [PTR_W-1:0]     rd_ptr,
    input  logic [PTR_W-1:0]     wr_ptr,
    input  logic [ADDR_W-3:0]    ld_word,
    input  logic [3:0]           ld_byteen,
    output logic [31:0]          fwddata,
    output logic [3:0]           fwdbyteen
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]        count;
    logic [IDX_W-1:0]        age_idx [DEPTH];
    logic [STBUF_ADDR_W-1:0] ld_addr_aligned;

    assign count           = wr_ptr - rd_ptr;
    assign ld_addr_aligned = STBUF_ADDR_W'({ld_word, 2'b00});

    // Slot index of the i-th oldest entry, wrapping around the ring.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx[i] = rd_ptr[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // Walk oldest to youngest so the youngest hit on each byte wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a byte
        // with no hit would hold its old value and infer a latch.
        fwddata   = '0;
        fwdbyteen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W'(i) < count) && entries[age_idx[i]].valid &&
                (entries[age_idx[i]].addr == ld_addr_aligned)) begin
                for (int b = 0; b < 4; b++) begin
                    if (ld_byteen[b] && entries[age_idx[i]].byteen[b]) begin
                        fwddata[8*b +: 8] = entries[age_idx[i]].data[8*b +: 8];
                        fwdbyteen[b]      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mcu_el2_lsu_store_queue.sv
// In-order store queue between LSU r-stage commit and the DCCM write port.
// Drains one entry per DCCM acknowledge and forwards pending bytes to loads.
// ADDR_W must not exceed STBUF_ADDR_W.
module mcu_el2_lsu_store_queue
    import mcu_el2_pkg::*;
#(
    parameter int DEPTH  = STBUF_DEPTH,
    parameter int ADDR_W = STBUF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              ldst_stbuf_reqvld_r,
    input  logic [ADDR_W-1:0] alloc_addr_r,
    input  logic [31:0]       alloc_data_r,
    input  logic [3:0]        alloc_byteen_r,
    input  logic              stbuf_ack_any,
    input  logic [ADDR_W-1:0] ld_addr_m,
    input  logic [3:0]        ld_byteen_m,
    output logic              stbuf_reqvld_any,
    output logic [ADDR_W-1:0] stbuf_addr_any,
    output logic [31:0]       stbuf_data_any,
    output logic [3:0]        stbuf_byteen_any,
    output logic              lsu_stbuf_empty_any,
    output logic              lsu_stbuf_full_any,
    output logic [31:0]       stbuf_fwddata_m,
    output logic [3:0]        stbuf_fwdbyteen_m
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic [DEPTH-1:0]     valid_q;
    logic [ADDR_W-1:0]    addr_q   [DEPTH];
    logic [31:0]          data_q   [DEPTH];
    logic [3:0]           byteen_q [DEPTH];
    mcu_el2_stbuf_entry_t entries  [DEPTH];

    logic ptr_empty, ptr_full, head_valid, drain, alloc;
    logic unused_addr_lsbs;

    assign wr_idx     = wr_ptr[IDX_W-1:0];
    assign rd_idx     = rd_ptr[IDX_W-1:0];
    assign ptr_empty  = (wr_ptr == rd_ptr);
    assign ptr_full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign head_valid = valid_q[rd_idx];

    // A same-cycle ack frees the head slot, so allocate is still legal when full.
    // An allocate into an empty queue is never acked in its own cycle.
    assign drain = stbuf_ack_any & head_valid;
    assign alloc = ldst_stbuf_reqvld_r & (~ptr_full | drain);

    // Byte-offset bits are ignored on both the store and load address.
    assign unused_addr_lsbs = ^{alloc_addr_r[1:0], ld_addr_m[1:0]};

    // Ring pointers: advance on accepted allocate and on drain.
    always_ff @(posedge clk or negedge rst_l) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Valid bits: clear on drain, set on allocate. When full, both hit the
    // same slot; the later assignment (allocate) wins, keeping the slot live.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= '0;
        end else begin
            if (drain) valid_q[rd_idx] <= 1'b0;
            if (alloc) valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload: written only on accepted allocate.
    // NOTE: the payload array has no reset; every reader qualifies it with the
    // reset-cleared valid bits, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_idx]   <= {alloc_addr_r[ADDR_W-1:2], 2'b00};
            data_q[wr_idx]   <= alloc_data_r;
            byteen_q[wr_idx] <= alloc_byteen_r;
        end
    end

    // Packed view of the registered entries for the forwarding network.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = '{valid:  valid_q[i],
                           addr:   STBUF_ADDR_W'(addr_q[i]),
                           data:   data_q[i],
                           byteen: byteen_q[i]};
        end
    end

    // Head outputs come straight from registers, gated by the head valid bit.
    assign stbuf_reqvld_any    = head_valid;
    assign stbuf_addr_any      = head_valid ? addr_q[rd_idx]   : '0;
    assign stbuf_data_any      = head_valid ? data_q[rd_idx]   : '0;
    assign stbuf_byteen_any    = head_valid ? byteen_q[rd_idx] : '0;
    assign lsu_stbuf_empty_any = ptr_empty & ~ldst_stbuf_reqvld_r;
    assign lsu_stbuf_full_any  = ptr_full;

    mcu_el2_lsu_stbuf_fwd #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_fwd (
        .entries   (entries),
        .rd_ptr    (rd_ptr),
        .wr_ptr    (wr_ptr),
        .ld_word   (ld_addr_m[ADDR_W-1:2]),
        .ld_byteen (ld_byteen_m),
        .fwddata   (stbuf_fwddata_m),
        .fwdbyteen (stbuf_fwdbyteen_m)
    );

endmodule

// File: doc/mcu_el2_lsu_store_queue.md
# mcu_el2_lsu_store_queue

The store queue holds committed stores from the LSU r-stage until the DCCM write port accepts them, and forwards pending bytes to younger loads. It sits downstream of the LSU clock-domain block and is clocked by the store-buffer gated clock. It produces the drain-request and empty status that feed that block's clock enables. Entries are drained in order, one per DCCM acknowledge.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- ADDR_W, 32: byte address width.
- clk  in  1  store-buffer clock; connected to `lsu_stbuf_c1_clk`.
- rst_l  in  1  reset; asynchronous, active-low.
- ldst_stbuf_reqvld_r  in  1  allocate a store this cycle.
- alloc_addr_r  in  ADDR_W  store word address; bits [1:0] are ignored.
- alloc_data_r  in  32  store data, byte-lane aligned.
- alloc_byteen_r  in  4  byte enables; must be non-zero.
- stbuf_ack_any  in  1  DCCM accepted the head entry this cycle.
- ld_addr_m  in  ADDR_W  load address for forwarding.
- ld_byteen_m  in  4  bytes the load needs.
- stbuf_reqvld_any  out  1  head entry valid; drain request.
- stbuf_addr_any  out  ADDR_W  head address.
- stbuf_data_any  out  32  head data.
- stbuf_byteen_any  out  4  head byte enables.
- lsu_stbuf_empty_any  out  1  no valid entries and no allocate this cycle.
- lsu_stbuf_full_any  out  1  count == DEPTH.
- stbuf_fwddata_m  out  32  forwarded bytes.
- stbuf_fwdbyteen_m  out  4  per-byte forward hit.

## Operation
- Circular buffer with write pointer wr_ptr and read pointer rd_ptr.
  - Each pointer is log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - count = wr_ptr − rd_ptr, taken modulo 2·DEPTH.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Allocate: write addr, data and byteen into entry wr_ptr, set its valid bit, then increment wr_ptr.
- Drain: when stbuf_ack_any is high and the head is valid, clear the head's valid bit and increment rd_ptr.
- Allocate and drain in the same cycle:
  - Both take effect and count is unchanged.
  - This is legal when full (the drain frees the slot) and when empty (the new entry is not acknowledged).
- Allocate while full without a same-cycle ack is illegal. A bench assertion checks it; the RTL drops the store and leaves all state unchanged.
- An ack while empty is ignored.
- No coalescing: every allocate consumes exactly one entry.
- Forwarding (combinational, current entries only):
  - For each byte b where ld_byteen_m[b] is set, search the valid entries from youngest to oldest.
  - A hit is an entry whose address [ADDR_W−1:2] equals the load's and whose byteen[b] is set.
  - The youngest hit supplies byte b and sets stbuf_fwdbyteen_m[b].
  - Bytes with no hit, and bytes the load does not need, are 0 in both fwddata and fwdbyteen.
- A store allocated in the same cycle is not visible to forwarding; the upstream pipeline covers that case.

## Timing
- Reset values:
  - All valid bits 0; wr_ptr = rd_ptr = 0.
  - stbuf_reqvld_any = 0, lsu_stbuf_empty_any = 1, lsu_stbuf_full_any = 0.
  - stbuf_addr_any, stbuf_data_any, stbuf_byteen_any, stbuf_fwddata_m, stbuf_fwdbyteen_m all 0.
- Reset mid-operation discards every entry immediately and asynchronously; no drain follows.
- Allocate at cycle t: the entry is visible at t+1, and stbuf_reqvld_any rises at t+1 at the earliest.
- Ack at cycle t: the next head is presented at t+1.
  - Back-to-back acks drain one entry per cycle.
  - stbuf_reqvld_any falls at t+1 if the queue becomes empty.
- Head outputs come from registered entries with no combinational path from the ack.
- lsu_stbuf_empty_any is combinational on ldst_stbuf_reqvld_r. This keeps the free clock enabled in the allocate cycle.
- Storage changes only on an allocate or an ack. It is therefore safe on the gated clock, whose enable covers ldst_stbuf_reqvld_r | stbuf_reqvld_any.

## Structure
- Add `mcu_el2_stbuf_entry_t` (valid, addr, data, byteen) and a localparam STBUF_PTR_W = $clog2(DEPTH)+1 to `mcu_el2_pkg`.
- One sub-module, `mcu_el2_lsu_stbuf_fwd`: the purely combinational youngest-first byte-merge over the entry array and pointers.
- Registers use the codebase's async-reset flop primitives.

## Test plan
- Reset, then allocate addr 0x100, data 0xAABBCCDD, byteen 0xF.
  - Next cycle: stbuf_reqvld_any=1, stbuf_addr_any=0x100, lsu_stbuf_empty_any=0.
  - Ack → empty again one cycle later.
- Fill DEPTH=4 entries (0x0, 0x4, 0x8, 0xC).
  - full=1 after the 4th allocate.
  - Allocate plus ack in the same cycle → head becomes 0x4, full stays 1, the new entry lands at slot 0 (wrap).
- Allocate 0x200/0x11111111/0xF, then 0x200/0x22220000/0xC. Load at 0x200 with byteen 0xF → fwddata=0x22221111, fwdbyteen=0xF.
- Empty queue, allocate and ack in the same cycle → entry retained, stbuf_reqvld_any=1 next cycle, count=1.
- Three entries valid, assert rst_l=0 mid-cycle → all outputs reach reset values without waiting for a clock edge. After release, a load to 0x0 → fwdbyteen=0.
- Allocate while full with no ack → assertion fires, pointers unchanged, stored data unchanged.
